// File: rtl/tmr_pkg.sv
// tmr_pkg: shared widths, scrub FSM state type and a saturating
// increment used by the scrub controller and its voter.
package tmr_pkg;

  localparam int DATA_W = 192;
  localparam int WORD_W = 16;
  localparam int WORDS  = 12;

  typedef enum logic [2:0] {
    IDLE,
    RD,
    VOTE,
    WR,
    NEXT
  } state_e;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/tmr_scrub_controller_voter.sv
// TMR_Voter: bitwise 2-of-3 majority over a 192-bit triplicated entry.
// Ports: a_i/b_i/c_i copies in; voted_o majority; error_flags_o[w]=1
// when all three copies of 16-bit word w differ pairwise.
module TMR_Voter
  import tmr_pkg::*;
(
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  input  logic [DATA_W-1:0] c_i,
  output logic [DATA_W-1:0] voted_o,
  output logic [WORDS-1:0]  error_flags_o
);

  assign voted_o = (a_i & b_i) | (a_i & c_i) | (b_i & c_i);

  for (genvar w = 0; w < WORDS; w++) begin : g_word
    logic [WORD_W-1:0] a, b, c;
    assign a = a_i[w*WORD_W +: WORD_W];
    assign b = b_i[w*WORD_W +: WORD_W];
    assign c = c_i[w*WORD_W +: WORD_W];
    assign error_flags_o[w] = (a != b) && (a != c) && (b != c);
  end

endmodule

// File: rtl/tmr_scrub_controller.sv
// tmr_scrub_controller: walks DEPTH triplicated entries, votes each one,
// writes back corrected data and keeps saturating error statistics.
// Ports: clk/rst_n; enable_i, scrub_now_i, clear_i controls;
// mem_rd_req_o/mem_rd_ack_i/copy1..3_i read side; mem_wr_req_o/
// mem_wr_data_o/mem_wr_ack_i write side; mem_addr_o shared address;
// busy_o, pass_done_o, corrected_cnt_o, uncorr_cnt_o, fault_o,
// fault_addr_o, timeout_o status.
module tmr_scrub_controller
  import tmr_pkg::*;
#(
  parameter int DEPTH          = 16,
  parameter int SCRUB_INTERVAL = 1024,
  parameter int ACK_TIMEOUT    = 255
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     enable_i,
  input  logic                     scrub_now_i,
  input  logic                     clear_i,
  output logic                     mem_rd_req_o,
  output logic [$clog2(DEPTH)-1:0] mem_addr_o,
  input  logic                     mem_rd_ack_i,
  input  logic [DATA_W-1:0]        copy1_i,
  input  logic [DATA_W-1:0]        copy2_i,
  input  logic [DATA_W-1:0]        copy3_i,
  output logic                     mem_wr_req_o,
  output logic [DATA_W-1:0]        mem_wr_data_o,
  input  logic                     mem_wr_ack_i,
  output logic                     busy_o,
  output logic                     pass_done_o,
  output logic [15:0]              corrected_cnt_o,
  output logic [15:0]              uncorr_cnt_o,
  output logic                     fault_o,
  output logic [$clog2(DEPTH)-1:0] fault_addr_o,
  output logic                     timeout_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int IW = $clog2(SCRUB_INTERVAL + 1);
  localparam int TW = $clog2(ACK_TIMEOUT + 1);
  localparam logic [AW-1:0] A_LAST = AW'(DEPTH - 1);
  localparam logic [IW-1:0] I_LAST = IW'(SCRUB_INTERVAL - 1);
  localparam logic [TW-1:0] T_LAST = TW'(ACK_TIMEOUT - 1);

  state_e            state_q, state_d;
  logic [AW-1:0]     addr_q, addr_d;
  logic [IW-1:0]     ival_q, ival_d;
  logic [TW-1:0]     wait_q, wait_d;
  logic              auto_q, auto_d;
  logic [DATA_W-1:0] cp1_q, cp1_d;
  logic [DATA_W-1:0] cp2_q, cp2_d;
  logic [DATA_W-1:0] cp3_q, cp3_d;
  logic [15:0]       corr_q, corr_d;
  logic [15:0]       unc_q, unc_d;
  logic              fault_q, fault_d;
  logic [AW-1:0]     faddr_q, faddr_d;
  logic              tmo_q, tmo_d;

  logic [DATA_W-1:0] voted;
  logic [WORDS-1:0]  err_flags;
  logic              mismatch;

  TMR_Voter u_voter (
    .a_i          (cp1_q),
    .b_i          (cp2_q),
    .c_i          (cp3_q),
    .voted_o      (voted),
    .error_flags_o(err_flags)
  );

  assign mismatch = (cp1_q != voted) || (cp2_q != voted) ||
                    (cp3_q != voted);

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    ival_d  = ival_q;
    wait_d  = wait_q;
    auto_d  = auto_q;
    cp1_d   = cp1_q;
    cp2_d   = cp2_q;
    cp3_d   = cp3_q;
    corr_d  = corr_q;
    unc_d   = unc_q;
    fault_d = fault_q;
    faddr_d = faddr_q;
    tmo_d   = tmo_q;
    unique case (state_q)
      IDLE: begin
        if (enable_i) ival_d = ival_q + 1'b1;
        if (scrub_now_i || (enable_i && ival_q == I_LAST)) begin
          state_d = RD;
          addr_d  = '0;
          ival_d  = '0;
          wait_d  = '0;
          // a manual request wins, so the pass ignores enable_i
          auto_d  = !scrub_now_i;
        end
      end
      RD: begin
        if (mem_rd_ack_i) begin
          cp1_d   = copy1_i;
          cp2_d   = copy2_i;
          cp3_d   = copy3_i;
          state_d = VOTE;
        end else if (wait_q == T_LAST) begin
          tmo_d   = 1'b1;
          state_d = IDLE;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      VOTE: begin
        wait_d = '0;
        if (|err_flags) begin
          unc_d   = sat_inc(unc_q);
          fault_d = 1'b1;
          if (!fault_q) faddr_d = addr_q;
          state_d = NEXT;
        end else if (mismatch) begin
          state_d = WR;
        end else begin
          state_d = NEXT;
        end
      end
      WR: begin
        if (mem_wr_ack_i) begin
          corr_d  = sat_inc(corr_q);
          state_d = NEXT;
        end else if (wait_q == T_LAST) begin
          tmo_d   = 1'b1;
          state_d = IDLE;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      NEXT: begin
        wait_d = '0;
        if (addr_q == A_LAST) begin
          state_d = IDLE;
        end else if (!enable_i && auto_q) begin
          state_d = IDLE;
        end else begin
          addr_d  = addr_q + 1'b1;
          state_d = RD;
        end
      end
      default: state_d = IDLE;
    endcase
    if (clear_i) begin
      corr_d  = '0;
      unc_d   = '0;
      fault_d = 1'b0;
      faddr_d = '0;
      tmo_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      ival_q  <= '0;
      wait_q  <= '0;
      auto_q  <= 1'b0;
      cp1_q   <= '0;
      cp2_q   <= '0;
      cp3_q   <= '0;
      corr_q  <= '0;
      unc_q   <= '0;
      fault_q <= 1'b0;
      faddr_q <= '0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      ival_q  <= ival_d;
      wait_q  <= wait_d;
      auto_q  <= auto_d;
      cp1_q   <= cp1_d;
      cp2_q   <= cp2_d;
      cp3_q   <= cp3_d;
      corr_q  <= corr_d;
      unc_q   <= unc_d;
      fault_q <= fault_d;
      faddr_q <= faddr_d;
      tmo_q   <= tmo_d;
    end
  end

  assign mem_rd_req_o    = (state_q == RD);
  assign mem_wr_req_o    = (state_q == WR);
  assign mem_wr_data_o   = (state_q == WR) ? voted : '0;
  assign mem_addr_o      = addr_q;
  assign busy_o          = (state_q != IDLE);
  assign pass_done_o     = (state_q == NEXT) && (addr_q == A_LAST);
  assign corrected_cnt_o = corr_q;
  assign uncorr_cnt_o    = unc_q;
  assign fault_o         = fault_q;
  assign fault_addr_o    = faddr_q;
  assign timeout_o       = tmo_q;

endmodule

// File: tb/tb_tmr_scrub_controller.sv
// tb_tmr_scrub_controller: randomized memory responder plus scoreboard
// of expected read/write/done events from a word-level vote model.
module tb_tmr_scrub_controller;
  import tmr_pkg::*;

  localparam int DEPTH = 16;

  logic clk = 0, rst_n = 0;
  logic enable_i = 0, scrub_now_i = 0, clear_i = 0;
  logic mem_rd_ack_i = 0, mem_wr_ack_i = 0;
  logic [191:0] copy1_i = '0, copy2_i = '0, copy3_i = '0;
  logic mem_rd_req_o, mem_wr_req_o, busy_o, pass_done_o;
  logic fault_o, timeout_o;
  logic [3:0] mem_addr_o, fault_addr_o;
  logic [191:0] mem_wr_data_o;
  logic [15:0] corrected_cnt_o, uncorr_cnt_o;

  always #5 clk = ~clk;

  tmr_scrub_controller #(
    .DEPTH(DEPTH), .SCRUB_INTERVAL(8), .ACK_TIMEOUT(255)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable_i(enable_i),
    .scrub_now_i(scrub_now_i), .clear_i(clear_i),
    .mem_rd_req_o(mem_rd_req_o), .mem_addr_o(mem_addr_o),
    .mem_rd_ack_i(mem_rd_ack_i), .copy1_i(copy1_i),
    .copy2_i(copy2_i), .copy3_i(copy3_i),
    .mem_wr_req_o(mem_wr_req_o), .mem_wr_data_o(mem_wr_data_o),
    .mem_wr_ack_i(mem_wr_ack_i), .busy_o(busy_o),
    .pass_done_o(pass_done_o), .corrected_cnt_o(corrected_cnt_o),
    .uncorr_cnt_o(uncorr_cnt_o), .fault_o(fault_o),
    .fault_addr_o(fault_addr_o), .timeout_o(timeout_o)
  );

  logic [191:0] m1[DEPTH], m2[DEPTH], m3[DEPTH];
  bit no_ack = 0, hold_wr = 0;
  int tests = 0, fails = 0, done_cnt = 0;
  int exp_corr = 0, exp_unc = 0, exp_faddr = 0;
  bit exp_fault = 0, exp_tmo = 0;

  typedef struct {
    int kind;
    int addr;
    logic [191:0] data;
  } ev_t;
  ev_t exp_q[$];

  function automatic logic [191:0] rnd192();
    logic [191:0] r;
    for (int i = 0; i < 6; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // 0 clean, 1 correctable (data returned), 2 uncorrectable
  function automatic int vote_model(input logic [191:0] a, b, c,
                                    output logic [191:0] v);
    int k = 0;
    v = '0;
    for (int w = 0; w < 12; w++) begin
      logic [15:0] x, y, z;
      x = a[w*16 +: 16];
      y = b[w*16 +: 16];
      z = c[w*16 +: 16];
      if (x == y || x == z) v[w*16 +: 16] = x;
      else if (y == z) v[w*16 +: 16] = y;
      else k = 2;
    end
    if (k == 0 && (a != v || b != v || c != v)) k = 1;
    return k;
  endfunction

  task automatic chk(input string name, input logic [191:0] got,
                     input logic [191:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h expected=%0h", name, got, exp);
    end
  endtask

  task automatic check_ev(input int kind, input int addr,
                          input logic [191:0] data);
    ev_t e;
    tests++;
    if (exp_q.size() == 0) begin
      fails++;
      $display("FAIL unexpected_event kind=%0d addr=%0d", kind, addr);
      return;
    end
    e = exp_q.pop_front();
    if (e.kind != kind || e.addr != addr || e.data !== data) begin
      fails++;
      $display("FAIL event got kind=%0d addr=%0d data=%h expected kind=%0d addr=%0d data=%h",
               kind, addr, data, e.kind, e.addr, e.data);
    end
  endtask

  // memory responder: random ack latency, stray acks with junk data
  initial forever begin
    @(posedge clk);
    #2;
    mem_rd_ack_i = 0;
    mem_wr_ack_i = 0;
    copy1_i = rnd192();
    copy2_i = rnd192();
    copy3_i = rnd192();
    if (!rst_n) continue;
    if (mem_rd_req_o) begin
      if (!no_ack && $urandom_range(0, 2) == 0) begin
        mem_rd_ack_i = 1;
        copy1_i = m1[mem_addr_o];
        copy2_i = m2[mem_addr_o];
        copy3_i = m3[mem_addr_o];
      end
    end else if (!no_ack && $urandom_range(0, 7) == 0) begin
      mem_rd_ack_i = 1;
    end
    if (mem_wr_req_o) begin
      if (!hold_wr && $urandom_range(0, 2) == 0) mem_wr_ack_i = 1;
    end else if ($urandom_range(0, 7) == 0) begin
      mem_wr_ack_i = 1;
    end
  end

  // monitor
  always @(negedge clk) begin
    if (rst_n) begin
      if (mem_rd_req_o && mem_rd_ack_i)
        check_ev(0, int'(mem_addr_o), '0);
      if (mem_wr_req_o && mem_wr_ack_i) begin
        check_ev(1, int'(mem_addr_o), mem_wr_data_o);
        m1[mem_addr_o] = mem_wr_data_o;
        m2[mem_addr_o] = mem_wr_data_o;
        m3[mem_addr_o] = mem_wr_data_o;
      end
      if (pass_done_o) begin
        check_ev(2, 0, '0);
        done_cnt++;
      end
    end
  end

  task automatic push_ev(input int kind, input int addr,
                         input logic [191:0] data);
    ev_t e;
    e.kind = kind;
    e.addr = addr;
    e.data = data;
    exp_q.push_back(e);
  endtask

  task automatic expect_entries(input int last, input bit done);
    logic [191:0] v;
    int k;
    for (int a = 0; a <= last; a++) begin
      push_ev(0, a, '0);
      k = vote_model(m1[a], m2[a], m3[a], v);
      if (k == 2) begin
        exp_unc++;
        if (!exp_fault) begin
          exp_fault = 1;
          exp_faddr = a;
        end
      end else if (k == 1) begin
        push_ev(1, a, v);
        exp_corr++;
      end
    end
    if (done) push_ev(2, 0, '0);
  endtask

  task automatic fill(input bit rnd);
    logic [191:0] base;
    int r, w;
    for (int a = 0; a < DEPTH; a++) begin
      base = {24{8'hAA}};
      if (rnd) base = rnd192();
      m1[a] = base;
      m2[a] = base;
      m3[a] = base;
      if (rnd) begin
        r = $urandom_range(0, 15);
        w = $urandom_range(0, 11);
        if (r < 3) begin
          if (r == 0) m1[a][w*16 +: 16] ^= 16'($urandom) | 16'h1;
          if (r == 1) m2[a][w*16 +: 16] ^= 16'($urandom) | 16'h1;
          if (r == 2) m3[a][w*16 +: 16] ^= 16'($urandom) | 16'h1;
        end else if (r == 3) begin
          m2[a][w*16 +: 16] ^= 16'h0001;
          m3[a][w*16 +: 16] ^= 16'h0002;
        end
      end
    end
  endtask

  task automatic pulse_now();
    @(posedge clk);
    #1 scrub_now_i = 1;
    @(posedge clk);
    #1 scrub_now_i = 0;
  endtask

  task automatic wait_done(input int start);
    int n = 0;
    while (done_cnt == start && n < 4000) begin
      @(negedge clk);
      n++;
    end
    chk("pass_done_seen", 192'(done_cnt - start), 192'd1);
    repeat (2) @(negedge clk);
    chk("queue_drained", 192'(exp_q.size()), 192'd0);
  endtask

  task automatic run_pass(input bit extra);
    int start;
    expect_entries(DEPTH - 1, 1);
    start = done_cnt;
    pulse_now();
    if (extra) begin
      repeat (5) @(posedge clk);
      pulse_now();
    end
    wait_done(start);
  endtask

  task automatic check_counters();
    @(negedge clk);
    chk("corrected_cnt", 192'(corrected_cnt_o), 192'(exp_corr));
    chk("uncorr_cnt", 192'(uncorr_cnt_o), 192'(exp_unc));
    chk("fault", 192'(fault_o), 192'(exp_fault));
    chk("timeout", 192'(timeout_o), 192'(exp_tmo));
    if (exp_fault)
      chk("fault_addr", 192'(fault_addr_o), 192'(exp_faddr));
  endtask

  task automatic model_clear();
    exp_corr = 0;
    exp_unc = 0;
    exp_fault = 0;
    exp_faddr = 0;
    exp_tmo = 0;
  endtask

  initial begin
    int n, k, start;
    fill(0);
    repeat (3) @(negedge clk);
    chk("rst_busy", 192'(busy_o), 0);
    chk("rst_rd_req", 192'(mem_rd_req_o), 0);
    chk("rst_wr_req", 192'(mem_wr_req_o), 0);
    chk("rst_addr", 192'(mem_addr_o), 0);
    chk("rst_pass_done", 192'(pass_done_o), 0);
    check_counters();
    @(posedge clk);
    #1 rst_n = 1;

    // clean AA pattern, extra scrub_now while busy
    run_pass(1);
    check_counters();

    // entry 5 single-word correction
    m1[5] = '0;
    m2[5] = '0;
    m3[5] = '0;
    m3[5][15:0] = 16'h0001;
    run_pass(0);
    check_counters();
    chk("req023_corr", 192'(corrected_cnt_o), 192'd1);

    // uncorrectable entries 9 then 12
    fill(0);
    m1[9][191:176] = 16'h2222;
    m2[9][191:176] = 16'h3333;
    m3[9][191:176] = 16'h4444;
    m1[12][15:0] = 16'h1111;
    m2[12][15:0] = 16'h5555;
    run_pass(0);
    check_counters();
    chk("req024_faddr", 192'(fault_addr_o), 192'd9);

    for (int p = 0; p < 3; p++) begin
      fill(1);
      run_pass(p == 1);
      check_counters();
    end

    // reset while a write-back is pending
    fill(0);
    m3[4][15:0] = 16'h0001;
    hold_wr = 1;
    for (int a = 0; a <= 4; a++) push_ev(0, a, '0);
    pulse_now();
    k = 0;
    while (!mem_wr_req_o && k < 2000) begin
      @(negedge clk);
      k++;
    end
    chk("wr_req_reached", 192'(mem_wr_req_o), 1);
    #2 rst_n = 0;
    #1;
    chk("arst_wr_req", 192'(mem_wr_req_o), 0);
    chk("arst_wr_data", mem_wr_data_o, 0);
    chk("arst_busy", 192'(busy_o), 0);
    chk("arst_addr", 192'(mem_addr_o), 0);
    chk("arst_corr", 192'(corrected_cnt_o), 0);
    chk("arst_fault", 192'(fault_o), 0);
    chk("arst_queue", 192'(exp_q.size()), 0);
    exp_q.delete();
    hold_wr = 0;
    model_clear();
    @(posedge clk);
    #1 rst_n = 1;
    run_pass(0);
    check_counters();

    // automatic pass, enable dropped at address 3
    fill(0);
    m1[2][95:80] = 16'hBEEF;
    expect_entries(3, 0);
    start = done_cnt;
    @(posedge clk);
    #1 enable_i = 1;
    n = 0;
    while (n < 100) begin
      @(negedge clk);
      if (mem_rd_req_o) break;
      n++;
    end
    chk("auto_idle_cycles", 192'(n), 192'd8);
    k = 0;
    while (!(mem_rd_req_o && mem_addr_o == 4'd3) && k < 2000) begin
      @(negedge clk);
      k++;
    end
    enable_i = 0;
    k = 0;
    while (busy_o && k < 2000) begin
      @(negedge clk);
      k++;
    end
    repeat (3) @(negedge clk);
    chk("auto_stop_idle", 192'(busy_o), 0);
    chk("auto_no_done", 192'(done_cnt - start), 0);
    chk("auto_queue", 192'(exp_q.size()), 0);
    check_counters();

    // read ack never arrives
    no_ack = 1;
    start = done_cnt;
    pulse_now();
    n = 0;
    k = 0;
    while (!timeout_o && k < 1000) begin
      @(negedge clk);
      if (mem_rd_req_o) n++;
      k++;
    end
    exp_tmo = 1;
    chk("tmo_req_cycles", 192'(n), 192'd255);
    chk("tmo_idle", 192'(busy_o), 0);
    chk("tmo_no_done", 192'(done_cnt - start), 0);
    check_counters();
    no_ack = 0;
    @(posedge clk);
    #1 clear_i = 1;
    @(posedge clk);
    #1 clear_i = 0;
    model_clear();
    check_counters();

    // clear on the same cycle as a correction
    fill(0);
    m2[7][63:48] = 16'h0F0F;
    fork
      run_pass(0);
      begin
        k = 0;
        while (k < 2000) begin
          @(negedge clk);
          k++;
          if (mem_wr_req_o && mem_wr_ack_i) begin
            clear_i = 1;
            @(posedge clk);
            #1 clear_i = 0;
            break;
          end
        end
      end
    join
    model_clear();
    check_counters();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/tmr_scrub_controller.md
TMR_SCRUB_CONTROLLER -- requirements
Module: tmr_scrub_controller

Interface
REQ-001 SHALL have parameter DEPTH, default 16: number of triplicated 192-bit entries scrubbed per pass (power of two, >=2).
REQ-002 SHALL have parameter SCRUB_INTERVAL, default 1024: idle cycles between automatic passes.
REQ-003 SHALL have parameter ACK_TIMEOUT, default 255: maximum cycles a request waits for its ack.
REQ-004 SHALL have one clock and an asynchronous, active-low reset; ports (clock and reset first):
- clk  in  1  sole clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- enable_i  in  1  permits automatic passes
- scrub_now_i  in  1  single-cycle request to start a pass immediately
- clear_i  in  1  clears counters and sticky flags
- mem_rd_req_o  out  1  read request to all three copies
- mem_addr_o  out  $clog2(DEPTH)  entry address for read/write
- mem_rd_ack_i  in  1  read data valid
- copy1_i / copy2_i / copy3_i  in  192 each  read data of the three copies
- mem_wr_req_o  out  1  write-back request to all three copies
- mem_wr_data_o  out  192  voted data to write back
- mem_wr_ack_i  in  1  write complete
- busy_o  out  1  pass in progress
- pass_done_o  out  1  one-cycle pulse at the end of a completed pass
- corrected_cnt_o  out  16  entries corrected by write-back
- uncorr_cnt_o  out  16  entries with at least one word in which all three copies differ
- fault_o  out  1  sticky: uncorrectable entry seen
- fault_addr_o  out  $clog2(DEPTH)  address of the first uncorrectable entry since clear
- timeout_o  out  1  sticky: ack timeout occurred

Function
REQ-005 SHALL use FSM states IDLE, RD, VOTE, WR, NEXT.
REQ-006 IDLE: the interval counter SHALL increment while enable_i=1 and hold otherwise; the block SHALL go to RD at address 0 when the counter reaches SCRUB_INTERVAL-1 or scrub_now_i=1, and the counter SHALL be cleared on start.
REQ-007 RD: mem_rd_req_o=1 and mem_addr_o stable until the cycle mem_rd_ack_i=1; copies SHALL be latched that cycle, then go to VOTE.
REQ-008 VOTE (exactly 1 cycle): the latched copies feed the voter; mismatch = any copyN != voted; if error_flags!=0 -> increment uncorr_cnt_o, set fault_o (capture fault_addr_o only if fault_o was 0), go to NEXT with no write-back; else if mismatch -> go to WR; else -> NEXT.
REQ-009 WR: mem_wr_req_o=1 with mem_wr_data_o=voted and mem_addr_o held until mem_wr_ack_i=1; then increment corrected_cnt_o and go to NEXT.
REQ-010 NEXT: if address==DEPTH-1 -> pulse pass_done_o, go to IDLE; else if enable_i=0 and the pass was automatically triggered -> IDLE without pass_done_o; else address+1 -> RD.
REQ-011 An ack that arrives while its request is low SHALL be ignored.
REQ-012 If a request remains unacked for ACK_TIMEOUT cycles, the block SHALL set timeout_o, drop the request, and return to IDLE without pass_done_o.
REQ-013 Counters SHALL saturate at 16'hFFFF.
REQ-014 If clear_i coincides with an increment or flag set, clear SHALL win.
REQ-015 scrub_now_i while busy_o=1 SHALL be ignored.
REQ-016 busy_o SHALL be 1 in every state except IDLE.
REQ-017 A scrub_now_i-triggered pass SHALL complete regardless of enable_i.

Reset
REQ-018 rst_n low SHALL immediately force IDLE and set all outputs, counters, flags, the address and the interval counter to 0.
REQ-019 Reset mid-pass SHALL abandon the pass with no write-back.

Structure
REQ-020 A shared package tmr_pkg SHALL hold DATA_W=192, WORD_W=16, WORDS=12 and the FSM state enum.
REQ-021 SHALL instantiate exactly one existing TMR_Voter as its sole sub-module; no other voting logic is permitted besides the mismatch compare.

Verification
REQ-022 All copies equal 0xAA..AA, scrub_now_i pulse, DEPTH=16 -> 16 reads, 0 writes, pass_done_o once, counters 0.
REQ-023 Entry 5: copy3 word 0 = 0x0001, others 0 -> one write at addr 5 with data 0, corrected_cnt_o=1.
REQ-024 Entry 9: word 11 = 0x2222/0x3333/0x4444 -> no write, uncorr_cnt_o=1, fault_o=1, fault_addr_o=9; a second fault at 12 leaves fault_addr_o=9.
REQ-025 mem_rd_ack_i never asserted -> timeout_o=1 after 255 cycles, IDLE, no pass_done_o.
REQ-026 enable_i=1, SCRUB_INTERVAL=8 -> pass starts on the 8th idle cycle; enable_i dropped at addr 3 -> IDLE after addr 3.
REQ-027 rst_n asserted during WR -> outputs 0 asynchronously; clear_i on the same cycle as a correction -> corrected_cnt_o=0.
